// File: rtl/spi_cs_master_if.sv
// rtl/spi_cs_master_if.sv - request/response bundle between a host and spi_cs_master
interface spi_cs_master_if #(
  parameter int NUM_CS = 2,
  parameter int DATA_W = 16,
  parameter int DIV_W  = 8
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic              start;
  logic [CS_W-1:0]   cs_sel;
  logic [DATA_W-1:0] tx_data;
  logic [DIV_W-1:0]  div;
  logic              cpol;
  logic              cpha;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              err;

  modport master (
    output start, cs_sel, tx_data, div, cpol, cpha,
    input  busy, done, rx_data, err
  );

  modport slave (
    input  start, cs_sel, tx_data, div, cpol, cpha,
    output busy, done, rx_data, err
  );
endinterface

// File: rtl/spi_cs_master.sv
// rtl/spi_cs_master.sv - SPI master with per-channel chip selects; SPI_CS_MASTER_ERR_EN adds the err pulse
module spi_cs_master #(
  parameter int NUM_CS = 2,
  parameter int DATA_W = 16,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  spi_cs_master_if.slave    ctrl,
  output logic [NUM_CS-1:0] spi_csn,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic [NUM_CS-1:0] spi_miso
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int EW   = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_HALF = EW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state, state_n;

  logic [DIV_W-1:0]  div_cnt, div_q;
  logic [EW-1:0]     half_cnt, half_nxt;
  logic [CS_W-1:0]   sel_q, sel_n;
  logic              cpol_q, cpha_q;
  logic [DATA_W-1:0] tx_sh, rx_sh, rx_q;
  logic              busy_q, done_q, sclk_q, mosi_q;
  logic [NUM_CS-1:0] csn_q, csn_n;
  logic              accept, half_end, last_half, edge_go, lead_edge, adv_edge, smp_edge;

  // decode the request and the half-period / SCLK edge events of the current cycle
  always_comb begin
    accept    = (state == IDLE) && ctrl.start && (int'(ctrl.cs_sel) < NUM_CS);
    half_end  = (div_cnt == div_q);
    last_half = (half_cnt == LAST_HALF);
    edge_go   = half_end && ((state == SETUP) || ((state == SHIFT) && !last_half));
    half_nxt  = (state == SETUP) ? '0 : half_cnt + EW'(1);
    lead_edge = ~half_nxt[0];
    adv_edge  = edge_go && (cpha_q ? lead_edge : ~lead_edge);
    smp_edge  = edge_go && (cpha_q ? ~lead_edge : lead_edge);
    sel_n     = accept ? ctrl.cs_sel : sel_q;
    for (int i = 0; i < NUM_CS; i++) begin
      csn_n[i] = !((state_n != IDLE) && (sel_n == CS_W'(i)));
    end
  end

  // next-state logic: each phase ends on a half-period boundary
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = SETUP;
      SETUP:   if (half_end) state_n = SHIFT;
      SHIFT:   if (half_end && last_half) state_n = HOLD;
      HOLD:    if (half_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // registered datapath: latching, divider, shifting and all pins
  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_cnt  <= '0;
      div_q    <= '0;
      half_cnt <= '0;
      sel_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      csn_q    <= '1;
    end else begin
      busy_q <= (state_n != IDLE);
      done_q <= (state == HOLD) && half_end;
      csn_q  <= csn_n;
      if (state == IDLE) begin
        div_cnt  <= '0;
        half_cnt <= '0;
        sclk_q   <= ctrl.cpol;
        mosi_q   <= 1'b0;
        if (accept) begin
          sel_q  <= ctrl.cs_sel;
          div_q  <= ctrl.div;
          cpol_q <= ctrl.cpol;
          cpha_q <= ctrl.cpha;
          rx_sh  <= '0;
          if (ctrl.cpha) begin
            tx_sh <= ctrl.tx_data;
          end else begin
            mosi_q <= ctrl.tx_data[DATA_W-1];
            tx_sh  <= ctrl.tx_data << 1;
          end
        end
      end else begin
        div_cnt <= half_end ? '0 : div_cnt + DIV_W'(1);
        if (edge_go) begin
          half_cnt <= half_nxt;
          sclk_q   <= ~sclk_q;
        end
        if ((state == SHIFT) && half_end && last_half) sclk_q <= cpol_q;
        if (adv_edge) begin
          mosi_q <= tx_sh[DATA_W-1];
          tx_sh  <= tx_sh << 1;
        end
        if (smp_edge) rx_sh <= {rx_sh[DATA_W-2:0], spi_miso[sel_q]};
        if ((state == HOLD) && half_end) begin
          rx_q   <= rx_sh;
          mosi_q <= 1'b0;
          sclk_q <= ctrl.cpol;
        end
      end
    end
  end

`ifdef SPI_CS_MASTER_ERR_EN
  logic err_q;

  // flag every start request that is not taken
  always_ff @(posedge clk) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= ctrl.start && !accept;
  end

  assign ctrl.err = err_q;
`else
  assign ctrl.err = 1'b0;
`endif

  assign ctrl.busy    = busy_q;
  assign ctrl.done    = done_q;
  assign ctrl.rx_data = rx_q;
  assign spi_csn      = csn_q;
  assign spi_sclk     = sclk_q;
  assign spi_mosi     = mosi_q;
endmodule

// File: tb/tb_spi_cs_master.sv
// tb/tb_spi_cs_master.sv - directed self-checking bench for spi_cs_master
module tb_spi_cs_master;
`ifdef SPI_CS_MASTER_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  spi_cs_master_if #(.NUM_CS(2), .DATA_W(8),  .DIV_W(8)) c8  ();
  spi_cs_master_if #(.NUM_CS(3), .DATA_W(16), .DIV_W(8)) c16 ();

  logic [1:0] csn8;
  logic [1:0] miso8 = '0;
  logic       sclk8, mosi8;
  logic [2:0] csn16;
  logic [2:0] miso16 = '0;
  logic       sclk16, mosi16;

  spi_cs_master #(.NUM_CS(2), .DATA_W(8), .DIV_W(8)) u8 (
    .clk(clk), .rstn(rstn), .ctrl(c8),
    .spi_csn(csn8), .spi_sclk(sclk8), .spi_mosi(mosi8), .spi_miso(miso8)
  );

  spi_cs_master #(.NUM_CS(3), .DATA_W(16), .DIV_W(8)) u16 (
    .clk(clk), .rstn(rstn), .ctrl(c16),
    .spi_csn(csn16), .spi_sclk(sclk16), .spi_mosi(mosi16), .spi_miso(miso16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // slave model for the 8-bit master: shifts s8_data out, captures mosi, counts pulses
  logic [7:0] s8_data = '0, s8_sh = '0, s8_got = '0;
  logic       s8_sel = 1'b1, s8_cpol = 1'b0, s8_cpha = 1'b0;
  logic       s8_act = 1'b0, s8_prev = 1'b0, s8_bit = 1'b0;
  int         s8_pulses = 0;
  always @(negedge clk) begin
    logic lead;
    if (csn8[s8_sel]) begin
      s8_act = 1'b0;
      s8_sh  = s8_data;
      s8_bit = s8_data[7];
    end else if (!s8_act) begin
      s8_act    = 1'b1;
      s8_prev   = sclk8;
      s8_got    = '0;
      s8_pulses = 0;
    end else if (sclk8 !== s8_prev) begin
      lead    = (s8_prev == s8_cpol);
      s8_prev = sclk8;
      if (lead) s8_pulses++;
      if (lead ^ s8_cpha) begin
        s8_got = {s8_got[6:0], mosi8};
      end else if (s8_cpha) begin
        s8_bit = s8_sh[7];
        s8_sh  = s8_sh << 1;
      end else begin
        s8_sh  = s8_sh << 1;
        s8_bit = s8_sh[7];
      end
    end
    miso8         = 2'($urandom_range(0, 3));
    miso8[s8_sel] = s8_bit;
  end

  // slave model for the 16-bit master (mode 0 only)
  logic [15:0] s16_data = '0, s16_sh = '0, s16_got = '0;
  logic [1:0]  s16_sel = 2'd2;
  logic        s16_act = 1'b0, s16_prev = 1'b0, s16_bit = 1'b0;
  int          s16_pulses = 0;
  always @(negedge clk) begin
    logic lead;
    if (csn16[s16_sel]) begin
      s16_act = 1'b0;
      s16_sh  = s16_data;
      s16_bit = s16_data[15];
    end else if (!s16_act) begin
      s16_act    = 1'b1;
      s16_prev   = sclk16;
      s16_got    = '0;
      s16_pulses = 0;
    end else if (sclk16 !== s16_prev) begin
      lead     = (s16_prev == 1'b0);
      s16_prev = sclk16;
      if (lead) begin
        s16_pulses++;
        s16_got = {s16_got[14:0], mosi16};
      end else begin
        s16_sh  = s16_sh << 1;
        s16_bit = s16_sh[15];
      end
    end
    miso16          = 3'($urandom_range(0, 7));
    miso16[s16_sel] = s16_bit;
  end

  // runs one 8-bit transfer from cycle T+1 up to its done cycle, then checks it
  task automatic xfer8(input bit hold, input int inj, input logic [7:0] exp_rx,
                       input logic [7:0] exp_mosi, input string tag);
    int cyc = 1, low = 0, bad = 0, errs = 0;
    while (!c8.done && cyc < 100) begin
      if (csn8 == 2'b01) low++;
      else bad++;
      if (c8.err) errs++;
      if (inj > 0 && cyc == inj) begin
        c8.start   = 1'b1;
        c8.cs_sel  = 1'b0;
        c8.tx_data = 8'h00;
      end else if (!hold) begin
        c8.start  = 1'b0;
        c8.cs_sel = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_done_cycle"}, cyc, 37);
    chk({tag, "_csn_low_cycles"}, low, 36);
    chk({tag, "_csn_bad_cycles"}, bad, 0);
    chk({tag, "_busy_at_done"}, c8.busy, 0);
    chk({tag, "_csn_at_done"}, csn8, 2'b11);
    chk({tag, "_rx_data"}, c8.rx_data, exp_rx);
    chk({tag, "_mosi_bits"}, s8_got, exp_mosi);
    chk({tag, "_pulses"}, s8_pulses, 8);
    if (!hold) chk({tag, "_err_pulses"}, errs, (inj > 0) ? 32'(ERR_EN) : 0);
  endtask

  initial begin
    int cyc, tog, dones;
    logic ps;
    c8.start = 0;  c8.cs_sel = 0;  c8.tx_data = 0;  c8.div = 0;  c8.cpol = 0;  c8.cpha = 0;
    c16.start = 0; c16.cs_sel = 0; c16.tx_data = 0; c16.div = 0; c16.cpol = 0; c16.cpha = 0;

    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", c8.busy, 0);
    chk("rst_done", c8.done, 0);
    chk("rst_err", c8.err, 0);
    chk("rst_csn", csn8, 2'b11);
    chk("rst_sclk", sclk8, 0);
    chk("rst_mosi", mosi8, 0);
    chk("rst_rx", c8.rx_data, 0);
    chk("rst_csn16", csn16, 3'b111);
    rstn = 1'b1;
    @(posedge clk); #1;

    // mode 0, div=1, channel 1
    c8.div = 8'd1; c8.cpol = 0; c8.cpha = 0; c8.cs_sel = 1; c8.tx_data = 8'hA5;
    s8_data = 8'h3C; s8_cpol = 0; s8_cpha = 0; s8_sel = 1;
    c8.start = 1;
    @(posedge clk); #1;
    chk("m0_setup_busy", c8.busy, 1);
    chk("m0_setup_csn", csn8, 2'b01);
    chk("m0_setup_mosi", mosi8, 1);
    chk("m0_setup_sclk", sclk8, 0);
    xfer8(0, 0, 8'h3C, 8'hA5, "m0");

    // mode 3 with an ignored start injected mid-transfer
    c8.cpol = 1; c8.cpha = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("m3_idle_sclk", sclk8, 1);
    c8.tx_data = 8'h5A; s8_data = 8'hC3; s8_cpol = 1; s8_cpha = 1;
    c8.start = 1;
    @(posedge clk); #1;
    chk("m3_setup_sclk", sclk8, 1);
    chk("m3_setup_csn", csn8, 2'b01);
    xfer8(0, 6, 8'hC3, 8'h5A, "m3");

    // reset in the 10th cycle of a transfer
    c8.cpol = 0; c8.cpha = 0; c8.tx_data = 8'hF0; s8_data = 8'h0F; s8_cpol = 0; s8_cpha = 0;
    @(posedge clk); #1;
    c8.start = 1;
    @(posedge clk); #1;
    c8.start = 0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("abort_pre_busy", c8.busy, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("abort_csn", csn8, 2'b11);
    chk("abort_busy", c8.busy, 0);
    chk("abort_sclk", sclk8, 0);
    chk("abort_mosi", mosi8, 0);
    chk("abort_rx", c8.rx_data, 0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (c8.done) dones++;
    end
    chk("abort_no_done", dones, 0);
    c8.tx_data = 8'h81; s8_data = 8'h7E;
    c8.start = 1;
    @(posedge clk); #1;
    chk("restart_csn", csn8, 2'b01);
    xfer8(0, 0, 8'h7E, 8'h81, "restart");

    // start held high: back-to-back transfers, channel 0 toggling
    c8.tx_data = 8'h66; s8_data = 8'h99;
    @(posedge clk); #1;
    c8.start = 1;
    @(posedge clk); #1;
    xfer8(1, 0, 8'h99, 8'h66, "b2b0");
    c8.tx_data = 8'h18; s8_data = 8'h42;
    @(posedge clk); #1;
    chk("b2b_reaccept_busy", c8.busy, 1);
    chk("b2b_reaccept_csn", csn8, 2'b01);
    xfer8(0, 0, 8'h42, 8'h18, "b2b1");

    // 16-bit master: out-of-range channel, then div=0 full-speed transfer
    c16.div = 0; c16.cpol = 0; c16.cpha = 0; c16.cs_sel = 2'd3; c16.tx_data = 16'hFFFF;
    s16_data = 16'h96C3; s16_sel = 2'd2;
    c16.start = 1;
    @(posedge clk); #1;
    chk("oor_busy", c16.busy, 0);
    chk("oor_csn", csn16, 3'b111);
    chk("oor_err", c16.err, ERR_EN);
    c16.cs_sel = 2'd2;
    @(posedge clk); #1;
    c16.start = 0;
    chk("d0_setup_busy", c16.busy, 1);
    chk("d0_setup_csn", csn16, 3'b011);
    chk("d0_setup_mosi", mosi16, 1);
    cyc = 1; tog = 0; ps = sclk16;
    while (!c16.done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (sclk16 !== ps) tog++;
      ps = sclk16;
    end
    chk("d0_done_cycle", cyc, 35);
    chk("d0_sclk_toggles", tog, 32);
    chk("d0_pulses", s16_pulses, 16);
    chk("d0_rx_data", c16.rx_data, 16'h96C3);
    chk("d0_mosi_bits", s16_got, 16'hFFFF);
    chk("d0_busy_at_done", c16.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
